// File: rtl/etapa_busqueda_pkg.sv
// Shared widths, constants and the prefetch FIFO entry type for the fetch stage.
// Anything that needs a byte address aligned to a word boundary goes through alinear_dir.
package busqueda_pkg;

  localparam int ANCHO_PC   = 32;
  localparam int ANCHO_INST = 32;

  localparam logic [ANCHO_PC-1:0]   PC_RESET      = 32'h0000_0000;
  localparam logic [ANCHO_PC-1:0]   INCREMENTO_PC = 32'h0000_0004;
  localparam logic [ANCHO_INST-1:0] INST_NULA     = 32'h0000_0000;

  typedef struct packed {
    logic [ANCHO_PC-1:0]   pc;
    logic [ANCHO_INST-1:0] instruccion;
  } entrada_fifo_t;

  // Clears the two byte-offset bits so every fetch address is word aligned.
  function automatic logic [ANCHO_PC-1:0] alinear_dir(input logic [ANCHO_PC-1:0] dir);
    return dir & {{(ANCHO_PC-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/etapa_busqueda_if.sv
// Bus seen by the fetch stage: instruction-memory port, redirect input and the
// downstream valid/ready handshake. master = fetch stage, slave = its environment.
interface etapa_busqueda_if;
  import busqueda_pkg::*;

  logic                  mem_req;
  logic [ANCHO_PC-1:0]   mem_dir;
  logic                  mem_valido;
  logic [ANCHO_INST-1:0] mem_dato;
  logic                  salto_valido;
  logic [ANCHO_PC-1:0]   salto_dir;
  logic [ANCHO_INST-1:0] instruccion_r;
  logic [ANCHO_PC-1:0]   pc_inst;
  logic                  inst_valida;
  logic                  inst_listo;

  modport master (
    output mem_req, mem_dir, instruccion_r, pc_inst, inst_valida,
    input  mem_valido, mem_dato, salto_valido, salto_dir, inst_listo
  );

  modport slave (
    input  mem_req, mem_dir, instruccion_r, pc_inst, inst_valida,
    output mem_valido, mem_dato, salto_valido, salto_dir, inst_listo
  );

endinterface

// File: rtl/etapa_busqueda_chk.sv
// Invariants of the fetch stage: the issue credit never lets a response land in a
// full FIFO, and the fetch address stays word aligned.
module etapa_busqueda_chk #(
  parameter  int PROFUNDIDAD = 4,
  localparam int ANCHO_CNT   = $clog2(PROFUNDIDAD) + 1
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 push,
  input logic [ANCHO_CNT-1:0] count,
  input logic [1:0]           dir_bajo
);

  localparam logic [ANCHO_CNT-1:0] LLENO = ANCHO_CNT'(PROFUNDIDAD);

  a_sin_desborde: assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == LLENO)));
  a_dir_alineada: assert property (@(posedge clk) disable iff (!rst_n) dir_bajo == 2'b00);

endmodule

// File: rtl/etapa_busqueda_fifo_inst.sv
// Prefetch FIFO of {pc, instruction} entries. Pointers carry one extra wrap bit so
// full and empty are distinguishable; flush empties it and overrides push and pop.
module fifo_inst
  import busqueda_pkg::*;
#(
  parameter  int PROFUNDIDAD = 4,
  localparam int ANCHO_PTR   = $clog2(PROFUNDIDAD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  entrada_fifo_t      dato,
  output entrada_fifo_t      head,
  output logic [ANCHO_PTR:0] count
);

  entrada_fifo_t      mem_r [PROFUNDIDAD];
  logic [ANCHO_PTR:0] wr_ptr_r;
  logic [ANCHO_PTR:0] rd_ptr_r;
  logic               vacia_s;
  logic               escribe_s;
  logic               lee_s;

  // Port qualification, occupancy and head presentation (zero when empty).
  always_comb begin
    vacia_s   = (wr_ptr_r == rd_ptr_r);
    escribe_s = push && !flush;
    lee_s     = pop && !flush && !vacia_s;
    count     = wr_ptr_r - rd_ptr_r;
    if (vacia_s) begin
      head.pc          = {ANCHO_PC{1'b0}};
      head.instruccion = INST_NULA;
    end else begin
      head = mem_r[rd_ptr_r[ANCHO_PTR-1:0]];
    end
  end

  // Read/write pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(ANCHO_PTR+1){1'b0}};
      rd_ptr_r <= {(ANCHO_PTR+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(ANCHO_PTR+1){1'b0}};
      rd_ptr_r <= {(ANCHO_PTR+1){1'b0}};
    end else begin
      if (escribe_s) wr_ptr_r <= wr_ptr_r + {{ANCHO_PTR{1'b0}}, 1'b1};
      if (lee_s)     rd_ptr_r <= rd_ptr_r + {{ANCHO_PTR{1'b0}}, 1'b1};
    end
  end

  // Entry storage; contents are never observed while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (escribe_s) mem_r[wr_ptr_r[ANCHO_PTR-1:0]] <= dato;
  end

endmodule

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: owns the PC, issues one-deep reads to a 1-cycle memory,
// buffers responses in fifo_inst and flushes everything on a redirect.
module etapa_busqueda
  import busqueda_pkg::ANCHO_PC, busqueda_pkg::INCREMENTO_PC,
         busqueda_pkg::entrada_fifo_t, busqueda_pkg::alinear_dir;
#(
  parameter logic [ANCHO_PC-1:0] PC_RESET    = busqueda_pkg::PC_RESET,
  parameter int                  PROFUNDIDAD = 4
) (
  input logic              clk,
  input logic              rst_n,
  etapa_busqueda_if.master bus
);

  localparam int                 ANCHO_CNT = $clog2(PROFUNDIDAD) + 1;
  localparam logic [ANCHO_CNT:0] LIMITE    = (ANCHO_CNT+1)'(PROFUNDIDAD);

  logic [ANCHO_PC-1:0]  pc_r;
  logic [ANCHO_PC-1:0]  pc_req_r;
  logic                 en_vuelo_r;
  logic                 emite_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 valida_s;
  logic [ANCHO_CNT-1:0] count_s;
  entrada_fifo_t        entrada_s;
  entrada_fifo_t        head_s;

  // Issue credit counts buffered plus in-flight words; a same-cycle pop is not credited.
  // rst_n gates the request so it drops the instant reset is asserted.
  always_comb begin
    if (rst_n && !bus.salto_valido &&
        (({1'b0, count_s} + {{ANCHO_CNT{1'b0}}, en_vuelo_r}) < LIMITE)) begin
      emite_s = 1'b1;
    end else begin
      emite_s = 1'b0;
    end
    valida_s              = (count_s != {ANCHO_CNT{1'b0}}) && !bus.salto_valido;
    push_s                = bus.mem_valido && en_vuelo_r && !bus.salto_valido;
    pop_s                 = valida_s && bus.inst_listo;
    entrada_s.pc          = pc_req_r;
    entrada_s.instruccion = bus.mem_dato;
  end

  // PC, captured request PC and the single outstanding-request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= alinear_dir(PC_RESET);
      pc_req_r   <= alinear_dir(PC_RESET);
      en_vuelo_r <= 1'b0;
    end else if (bus.salto_valido) begin
      pc_r       <= alinear_dir(bus.salto_dir);
      en_vuelo_r <= 1'b0;
    end else if (emite_s) begin
      pc_r       <= pc_r + INCREMENTO_PC;
      pc_req_r   <= pc_r;
      en_vuelo_r <= 1'b1;
    end else if (bus.mem_valido) begin
      en_vuelo_r <= 1'b0;
    end
  end

  fifo_inst #(.PROFUNDIDAD(PROFUNDIDAD)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.salto_valido),
    .dato  (entrada_s),
    .head  (head_s),
    .count (count_s)
  );

  etapa_busqueda_chk #(.PROFUNDIDAD(PROFUNDIDAD)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .count    (count_s),
    .dir_bajo (pc_r[1:0])
  );

  // Bus outputs.
  always_comb begin
    bus.mem_req       = emite_s;
    bus.mem_dir       = pc_r;
    bus.inst_valida   = valida_s;
    bus.instruccion_r = head_s.instruccion;
    bus.pc_inst       = head_s.pc;
  end

endmodule

// File: tb/tb_etapa_busqueda.sv
// Bench for etapa_busqueda: directed phases then random redirect/stall traffic,
// checked every cycle against a queue-based reference model of the fetch stage.
module tb_etapa_busqueda;

  localparam int PROF = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  etapa_busqueda_if bus();
  etapa_busqueda_if bw();

  etapa_busqueda #(.PC_RESET(32'h0000_0000), .PROFUNDIDAD(PROF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  etapa_busqueda #(.PC_RESET(32'hFFFF_FFF8), .PROFUNDIDAD(PROF)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bw)
  );

  int errores = 0;
  int checks  = 0;

  // Reference model: fetch PC, one pending request, queue of buffered words.
  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;
  bit          m_pend;
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];

  logic        resp_v, resp_w;
  logic [31:0] resp_d, resp_dw;
  bit          e_req, e_val;
  logic [31:0] e_pc, e_inst;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  function automatic logic [31:0] memoria(input logic [31:0] dir);
    if (dir == 32'h0000_0000)      return 32'h2008_0005;
    else if (dir == 32'h0000_0004) return 32'h2009_0003;
    else                           return (dir * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic modelo_reset();
    m_pc   = 32'h0000_0000;
    m_pend = 1'b0;
    q_pc.delete();
    q_inst.delete();
  endtask

  task automatic comprobar_reset(input string tag);
    comprobar({tag, "_req"},   32'(bus.mem_req), 32'h0);
    comprobar({tag, "_dir"},   bus.mem_dir, 32'h0);
    comprobar({tag, "_val"},   32'(bus.inst_valida), 32'h0);
    comprobar({tag, "_inst"},  bus.instruccion_r, 32'h0);
    comprobar({tag, "_pc"},    bus.pc_inst, 32'h0);
    comprobar({tag, "_dir_w"}, bw.mem_dir, 32'hFFFF_FFF8);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.mem_valido = 1'b0; bus.mem_dato = 32'h0; bus.salto_valido = 1'b0;
    bus.salto_dir = 32'h0; bus.inst_listo = 1'b0;
    bw.mem_valido = 1'b0; bw.mem_dato = 32'h0; bw.salto_valido = 1'b0;
    bw.salto_dir = 32'h0; bw.inst_listo = 1'b1;
    resp_v = 1'b0; resp_w = 1'b0; resp_d = 32'h0; resp_dw = 32'h0;
    modelo_reset();
    repeat (2) @(posedge clk);
    #1;
    comprobar_reset("reset");
    rst_n = 1'b1;

    for (int n = 0; n < 320; n++) begin
      // Inputs for this cycle, driven just after the rising edge.
      bus.mem_valido = resp_v;
      bus.mem_dato   = resp_v ? resp_d : $urandom();
      bw.mem_valido  = resp_w;
      bw.mem_dato    = resp_dw;
      bus.salto_valido = 1'b0;
      bus.salto_dir    = 32'h0;
      if (n < 6)       bus.inst_listo = 1'b1;
      else if (n < 16) bus.inst_listo = 1'b0;
      else if (n < 30) begin
        bus.inst_listo = 1'b1;
        if (n == 18) begin
          bus.salto_valido = 1'b1;
          bus.salto_dir    = 32'h0000_0103;
        end
      end else if (n < 33) bus.inst_listo = 1'b0;
      else if (n < 40)     bus.inst_listo = 1'b1;
      else begin
        bus.inst_listo   = ($urandom_range(3, 0) != 0);
        bus.salto_valido = ($urandom_range(15, 0) == 0);
        bus.salto_dir    = $urandom();
      end

      if (n == 32) begin
        // Mid-stream reset while a response is on the bus.
        rst_n = 1'b0;
        #1;
        comprobar_reset("reset_async");
        rst_n = 1'b1;
        modelo_reset();
      end

      @(negedge clk);
      e_req  = !bus.salto_valido && ((q_pc.size() + (m_pend ? 1 : 0)) < PROF);
      e_val  = (q_pc.size() != 0) && !bus.salto_valido;
      e_pc   = (q_pc.size() != 0) ? q_pc[0] : 32'h0;
      e_inst = (q_pc.size() != 0) ? q_inst[0] : 32'h0;
      comprobar("mem_req",       32'(bus.mem_req), 32'(e_req));
      comprobar("mem_dir",       bus.mem_dir, m_pc);
      comprobar("inst_valida",   32'(bus.inst_valida), 32'(e_val));
      comprobar("pc_inst",       bus.pc_inst, e_pc);
      comprobar("instruccion_r", bus.instruccion_r, e_inst);

      // Directed expectations from the fetch timeline.
      if (n == 0) comprobar("arranque_dir0", bus.mem_dir, 32'h0);
      if (n == 1) comprobar("arranque_dir4", bus.mem_dir, 32'h4);
      if (n == 2) begin
        comprobar("arranque_dir8", bus.mem_dir, 32'h8);
        comprobar("arranque_val",  32'(bus.inst_valida), 32'h1);
        comprobar("arranque_pc",   bus.pc_inst, 32'h0);
        comprobar("arranque_inst", bus.instruccion_r, 32'h2008_0005);
      end
      if (n == 3) comprobar("segunda_pc", bus.pc_inst, 32'h4);
      if (n < 3) comprobar("wrap_dir", bw.mem_dir, 32'hFFFF_FFF8 + 32'(n) * 32'h4);
      if (n == 2) comprobar("wrap_pc_inst", bw.pc_inst, 32'hFFFF_FFF8);
      if (n == 15) comprobar("lleno_req", 32'(bus.mem_req), 32'h0);
      if (n == 18) comprobar("salto_val", 32'(bus.inst_valida), 32'h0);
      if (n == 19) begin
        comprobar("salto_dir",  bus.mem_dir, 32'h0000_0100);
        comprobar("salto_req",  32'(bus.mem_req), 32'h1);
      end
      if (n == 20) comprobar("salto_vacio", 32'(bus.inst_valida), 32'h0);
      if (n == 21) begin
        comprobar("salto_val3", 32'(bus.inst_valida), 32'h1);
        comprobar("salto_pc3",  bus.pc_inst, 32'h0000_0100);
      end
      if (n == 33) comprobar("rst_obsoleto", 32'(bus.inst_valida), 32'h0);
      if (n == 34) comprobar("rst_rearranque", bus.pc_inst, 32'h0);

      // Memory: answers every accepted request one cycle later.
      resp_v  = bus.mem_req;
      resp_d  = memoria(bus.mem_dir);
      resp_w  = bw.mem_req;
      resp_dw = memoria(bw.mem_dir);

      // Advance the model over this cycle's edge.
      if (bus.salto_valido) begin
        q_pc.delete();
        q_inst.delete();
        m_pend = 1'b0;
        m_pc   = bus.salto_dir & 32'hFFFF_FFFC;
      end else begin
        if (e_val && bus.inst_listo) begin
          void'(q_pc.pop_front());
          void'(q_inst.pop_front());
        end
        if (bus.mem_valido && m_pend) begin
          q_pc.push_back(m_pend_pc);
          q_inst.push_back(bus.mem_dato);
        end
        if (e_req) begin
          m_pend_pc = m_pc;
          m_pc      = m_pc + 32'h4;
          m_pend    = 1'b1;
        end else if (bus.mem_valido) begin
          m_pend = 1'b0;
        end
      end

      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule
